// File: rtl/psx_pkg.sv
// Shared types and constants for the PSX controller pad emulator.
package psx_pkg;

    typedef enum logic [2:0] {
        WAIT_ADDR,
        WAIT_POLL,
        DATA,
        IGNORE,
        DONE
    } psx_state_t;

    localparam logic [7:0] PSX_ID_DIGITAL       = 8'h41;
    localparam logic [7:0] PSX_ID_ANALOG        = 8'h73;
    localparam logic [7:0] PSX_REPLY_MAGIC      = 8'h5A;
    localparam logic [7:0] PSX_REPLY_IDLE       = 8'hFF;
    localparam logic [3:0] PSX_LAST_IDX_DIGITAL = 4'd4;
    localparam logic [3:0] PSX_LAST_IDX_ANALOG  = 4'd8;

endpackage

// File: rtl/psx_pad_reply_select.sv
// Maps a poll byte index onto the matching byte of the latched pad snapshot.
module psx_pad_reply_select
    import psx_pkg::*;
(
    input  logic [3:0]  byte_idx,
    input  logic [15:0] buttons,
    input  logic [31:0] sticks,
    output logic [7:0]  reply
);

    always_comb begin
        reply = PSX_REPLY_IDLE;
        case (byte_idx)
            4'd3:    reply = buttons[7:0];
            4'd4:    reply = buttons[15:8];
            4'd5:    reply = sticks[7:0];
            4'd6:    reply = sticks[15:8];
            4'd7:    reply = sticks[23:16];
            4'd8:    reply = sticks[31:24];
            default: reply = PSX_REPLY_IDLE;
        endcase
    end

endmodule

// File: rtl/psx_pad_emulator.sv
// PSX pad emulator: answers controller polls from the device port with
// registered reply bytes and acks, and captures the host's motor bytes.
module psx_pad_emulator
    import psx_pkg::*;
#(
    parameter logic [7:0] PAD_ADDR = 8'h01,
    parameter logic [7:0] CMD_POLL = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PPB_packet_reset,
    input  logic [7:0]  PPB_command,
    input  logic        PPB_command_strobe,
    output logic        PPB_ack_strobe,
    output logic [7:0]  PPB_reply,
    output logic        PPB_reply_en,
    input  logic [15:0] buttons,
    input  logic        analog_mode,
    input  logic [31:0] sticks,
    output logic [7:0]  motor_small,
    output logic [7:0]  motor_large,
    output logic        poll_done
);

    psx_state_t  state_q, state_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  last_idx_q, last_idx_d;
    logic [7:0]  reply_q, reply_d;
    logic        reply_en_q, reply_en_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic [15:0] btn_snap_q, btn_snap_d;
    logic [31:0] stick_snap_q, stick_snap_d;
    logic [7:0]  small_sh_q, small_sh_d;
    logic [7:0]  large_sh_q, large_sh_d;
    logic [7:0]  motor_small_q, motor_small_d;
    logic [7:0]  motor_large_q, motor_large_d;
    logic [3:0]  sel_idx;
    logic [7:0]  sel_reply;
    logic        strobe;

    // A packet reset in the same cycle as a strobe swallows the strobe.
    assign strobe  = PPB_command_strobe && !PPB_packet_reset;
    assign sel_idx = byte_idx_q + 4'd1;

    psx_pad_reply_select u_reply_select (
        .byte_idx (sel_idx),
        .buttons  (btn_snap_q),
        .sticks   (stick_snap_q),
        .reply    (sel_reply)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_ADDR;
            byte_idx_q    <= 4'd0;
            reply_q       <= PSX_REPLY_IDLE;
            reply_en_q    <= 1'b0;
            ack_q         <= 1'b0;
            done_q        <= 1'b0;
            last_idx_q    <= PSX_LAST_IDX_DIGITAL;
            btn_snap_q    <= 16'h0000;
            stick_snap_q  <= 32'h0000_0000;
            small_sh_q    <= 8'h00;
            large_sh_q    <= 8'h00;
            motor_small_q <= 8'h00;
            motor_large_q <= 8'h00;
        end else begin
            last_idx_q    <= last_idx_d;
            btn_snap_q    <= btn_snap_d;
            stick_snap_q  <= stick_snap_d;
            small_sh_q    <= small_sh_d;
            large_sh_q    <= large_sh_d;
            motor_small_q <= motor_small_d;
            motor_large_q <= motor_large_d;
            if (PPB_packet_reset) begin
                state_q    <= WAIT_ADDR;
                byte_idx_q <= 4'd0;
                reply_q    <= PSX_REPLY_IDLE;
                reply_en_q <= 1'b0;
                ack_q      <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                byte_idx_q <= byte_idx_d;
                reply_q    <= reply_d;
                reply_en_q <= reply_en_d;
                ack_q      <= ack_d;
                done_q     <= done_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (strobe) begin
            case (state_q)
                WAIT_ADDR: state_d = (PPB_command == PAD_ADDR) ? WAIT_POLL : IGNORE;
                WAIT_POLL: state_d = (PPB_command == CMD_POLL) ? DATA : IGNORE;
                DATA:      if (byte_idx_q == last_idx_q) state_d = DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        byte_idx_d    = byte_idx_q;
        reply_d       = reply_q;
        reply_en_d    = reply_en_q;
        ack_d         = 1'b0;
        done_d        = 1'b0;
        last_idx_d    = last_idx_q;
        btn_snap_d    = btn_snap_q;
        stick_snap_d  = stick_snap_q;
        small_sh_d    = small_sh_q;
        large_sh_d    = large_sh_q;
        motor_small_d = motor_small_q;
        motor_large_d = motor_large_q;
        if (strobe) begin
            case (state_q)
                WAIT_ADDR: begin
                    if (PPB_command == PAD_ADDR) begin
                        btn_snap_d   = buttons;
                        stick_snap_d = sticks;
                        last_idx_d   = analog_mode ? PSX_LAST_IDX_ANALOG : PSX_LAST_IDX_DIGITAL;
                        reply_d      = analog_mode ? PSX_ID_ANALOG : PSX_ID_DIGITAL;
                        reply_en_d   = 1'b1;
                        ack_d        = 1'b1;
                        byte_idx_d   = 4'd1;
                    end else begin
                        reply_d    = PSX_REPLY_IDLE;
                        reply_en_d = 1'b0;
                    end
                end
                WAIT_POLL: begin
                    if (PPB_command == CMD_POLL) begin
                        reply_d    = PSX_REPLY_MAGIC;
                        ack_d      = 1'b1;
                        byte_idx_d = 4'd2;
                    end else begin
                        reply_d    = PSX_REPLY_IDLE;
                        reply_en_d = 1'b0;
                    end
                end
                DATA: begin
                    byte_idx_d = sel_idx;
                    if (byte_idx_q == 4'd3) small_sh_d = PPB_command;
                    if (byte_idx_q == 4'd4) large_sh_d = PPB_command;
                    // The final byte may itself carry a motor value, so take the new shadows.
                    if (byte_idx_q == last_idx_q) begin
                        reply_d       = PSX_REPLY_IDLE;
                        reply_en_d    = 1'b0;
                        done_d        = 1'b1;
                        motor_small_d = small_sh_d;
                        motor_large_d = large_sh_d;
                    end else begin
                        reply_d = sel_reply;
                        ack_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PPB_reply      = reply_q;
    assign PPB_reply_en   = reply_en_q;
    assign PPB_ack_strobe = ack_q;
    assign poll_done      = done_q;
    assign motor_small    = motor_small_q;
    assign motor_large    = motor_large_q;

endmodule

// File: tb/tb_psx_pad_emulator.sv
// Bench for psx_pad_emulator: per-byte expectations {reply, reply_en, ack, poll_done}
// go through a scoreboard queue; ack pulses are counted by a monitor.
module tb_psx_pad_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        PPB_packet_reset;
    logic [7:0]  PPB_command;
    logic        PPB_command_strobe;
    logic        PPB_ack_strobe;
    logic [7:0]  PPB_reply;
    logic        PPB_reply_en;
    logic [15:0] buttons;
    logic        analog_mode;
    logic [31:0] sticks;
    logic [7:0]  motor_small;
    logic [7:0]  motor_large;
    logic        poll_done;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    psx_pad_emulator dut (
        .clk                (clk),
        .reset              (reset),
        .PPB_packet_reset   (PPB_packet_reset),
        .PPB_command        (PPB_command),
        .PPB_command_strobe (PPB_command_strobe),
        .PPB_ack_strobe     (PPB_ack_strobe),
        .PPB_reply          (PPB_reply),
        .PPB_reply_en       (PPB_reply_en),
        .buttons            (buttons),
        .analog_mode        (analog_mode),
        .sticks             (sticks),
        .motor_small        (motor_small),
        .motor_large        (motor_large),
        .poll_done          (poll_done)
    );

    always @(negedge clk) if (PPB_ack_strobe === 1'b1) ack_cnt++;

    function automatic logic [10:0] obs();
        return {PPB_reply, PPB_reply_en, PPB_ack_strobe, poll_done};
    endfunction

    // Idle cycle, then a one-cycle strobe; returns on the negedge after the strobe edge.
    task automatic drive_byte(input logic [7:0] c);
        @(negedge clk);
        PPB_command        = c;
        PPB_command_strobe = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        PPB_command        = 8'h00;
    endtask

    task automatic pkt_reset();
        @(negedge clk);
        PPB_packet_reset = 1'b1;
        @(negedge clk);
        PPB_packet_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL reset outputs: got %h expected %h", obs(), {8'hFF, 3'b000});
        end
        checks++;
        if ({motor_small, motor_large} !== 16'h0000) begin
            errors++;
            $display("FAIL reset motors: got %h expected 0000", {motor_small, motor_large});
        end
    endtask

    task automatic test_digital();
        logic [7:0]  cmds [6];
        logic [10:0] exps [6];
        logic [10:0] e;
        int a0;
        cmds = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
        exps = '{{8'h41, 3'b110}, {8'h5A, 3'b110}, {8'hFE, 3'b110}, {8'hFF, 3'b110},
                 {8'hFF, 3'b001}, {8'hFF, 3'b000}};
        analog_mode = 1'b0;
        buttons     = 16'hFFFE;
        @(posedge clk);
        a0 = ack_cnt;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exps[i]);
            drive_byte(cmds[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL digital byte %0d: got %h expected %h", i, obs(), e);
            end
        end
        @(posedge clk);
        checks++;
        if (ack_cnt - a0 !== 4) begin
            errors++;
            $display("FAIL digital acks: got %0d expected 4", ack_cnt - a0);
        end
    endtask

    task automatic test_analog();
        logic [7:0]  cmds [9];
        logic [10:0] exps [9];
        logic [10:0] e;
        int a0;
        cmds = '{8'h01, 8'h42, 8'h00, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        exps = '{{8'h41 ^ 8'h32, 3'b110}, {8'h5A, 3'b110}, {8'h7E, 3'b110}, {8'hBF, 3'b110},
                 {8'hF0, 3'b110}, {8'h10, 3'b110}, {8'h7F, 3'b110}, {8'h80, 3'b110},
                 {8'hFF, 3'b001}};
        pkt_reset();
        analog_mode = 1'b1;
        buttons     = 16'hBF7E;
        sticks      = 32'h807F10F0;
        @(posedge clk);
        a0 = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exps[i]);
            drive_byte(cmds[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL analog byte %0d: got %h expected %h", i, obs(), e);
            end
            if (i == 7) begin
                checks++;
                if ({motor_small, motor_large} !== 16'h0000) begin
                    errors++;
                    $display("FAIL analog motors early: got %h expected 0000",
                             {motor_small, motor_large});
                end
            end
        end
        checks++;
        if ({motor_small, motor_large} !== 16'hAA55) begin
            errors++;
            $display("FAIL analog motors: got %h expected AA55", {motor_small, motor_large});
        end
        @(posedge clk);
        checks++;
        if (ack_cnt - a0 !== 8) begin
            errors++;
            $display("FAIL analog acks: got %0d expected 8", ack_cnt - a0);
        end
        analog_mode = 1'b0;
    endtask

    task automatic test_memcard();
        logic [7:0] cmds [4];
        logic [10:0] e;
        int a0;
        cmds = '{8'h81, 8'h01, 8'h42, 8'h00};
        pkt_reset();
        @(posedge clk);
        a0 = ack_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'hFF, 3'b000});
            drive_byte(cmds[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL memcard byte %0d: got %h expected %h", i, obs(), e);
            end
        end
        @(posedge clk);
        checks++;
        if (ack_cnt - a0 !== 0) begin
            errors++;
            $display("FAIL memcard acks: got %0d expected 0", ack_cnt - a0);
        end
        pkt_reset();
        exp_q.push_back({8'h41, 3'b110});
        drive_byte(8'h01);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL memcard recover: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0]  cmds [3];
        logic [10:0] exps [3];
        logic [10:0] e;
        int a0;
        cmds = '{8'h01, 8'h43, 8'h00};
        exps = '{{8'h41, 3'b110}, {8'hFF, 3'b000}, {8'hFF, 3'b000}};
        pkt_reset();
        @(posedge clk);
        a0 = ack_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            drive_byte(cmds[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL bad_cmd byte %0d: got %h expected %h", i, obs(), e);
            end
        end
        @(posedge clk);
        checks++;
        if (ack_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL bad_cmd acks: got %0d expected 1", ack_cnt - a0);
        end
    endtask

    task automatic test_abort();
        logic [7:0]  cmds [4];
        logic [10:0] exps [4];
        logic [10:0] e;
        cmds = '{8'h01, 8'h42, 8'h00, 8'h11};
        exps = '{{8'h41, 3'b110}, {8'h5A, 3'b110}, {8'hFE, 3'b110}, {8'hFF, 3'b110}};
        pkt_reset();
        buttons = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            drive_byte(cmds[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL abort byte %0d: got %h expected %h", i, obs(), e);
            end
        end
        pkt_reset();
        checks++;
        if (obs() !== {8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL abort outputs: got %h expected %h", obs(), {8'hFF, 3'b000});
        end
        checks++;
        if ({motor_small, motor_large} !== 16'hAA55) begin
            errors++;
            $display("FAIL abort motors: got %h expected AA55", {motor_small, motor_large});
        end
        exp_q.push_back({8'h41, 3'b110});
        drive_byte(8'h01);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort restart: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0]  cmds [5];
        logic [10:0] exps [5];
        logic [10:0] e;
        cmds = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        exps = '{{8'h41, 3'b110}, {8'h5A, 3'b110}, {8'h34, 3'b110}, {8'h12, 3'b110},
                 {8'hFF, 3'b001}};
        pkt_reset();
        buttons = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exps[i]);
            drive_byte(cmds[i]);
            if (i == 0) buttons = 16'hFFFF;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL snapshot byte %0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_collision();
        logic [10:0] e;
        int a0;
        pkt_reset();
        @(posedge clk);
        a0 = ack_cnt;
        @(negedge clk);
        PPB_command        = 8'h01;
        PPB_command_strobe = 1'b1;
        PPB_packet_reset   = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
        PPB_packet_reset   = 1'b0;
        checks++;
        if (obs() !== {8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL collision outputs: got %h expected %h", obs(), {8'hFF, 3'b000});
        end
        // Still waiting for the address, so a fresh 01 must be answered.
        exp_q.push_back({8'h41, 3'b110});
        drive_byte(8'h01);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL collision restart: got %h expected %h", obs(), e);
        end
        @(posedge clk);
        checks++;
        if (ack_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL collision acks: got %0d expected 1", ack_cnt - a0);
        end
    endtask

    initial begin
        reset              = 1'b1;
        PPB_packet_reset   = 1'b0;
        PPB_command        = 8'h00;
        PPB_command_strobe = 1'b0;
        buttons            = 16'hFFFF;
        analog_mode        = 1'b0;
        sticks             = 32'h0;
        test_reset();
        test_digital();
        test_analog();
        test_memcard();
        test_bad_cmd();
        test_abort();
        test_snapshot();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psx_pad_emulator.md
Name: psx_pad_emulator

Overview:
- PPB consumer stage sitting directly downstream of the PSX device port.
- Turns the received command-byte stream into a standard controller poll response: per-byte reply data, reply enable and ack requests.
- Supports digital pad (ID 0x41) and analog pad (ID 0x73) modes, and captures the host's vibration-motor bytes.
- Button and stick state come from the board/test harness.

Parameters:
- PAD_ADDR, 8'h01, first command byte this device answers to.
- CMD_POLL, 8'h42, only second command byte that continues a packet.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- PPB_packet_reset  in  1  per-packet reset level from the port; sampled synchronously
- PPB_command  in  8  received command byte
- PPB_command_strobe  in  1  one-cycle pulse, PPB_command valid
- PPB_ack_strobe  out  1  one-cycle ack request to the port
- PPB_reply  out  8  next reply byte
- PPB_reply_en  out  1  drive the data line for the next byte
- buttons  in  16  active-low buttons; [7:0] = byte 3, [15:8] = byte 4
- analog_mode  in  1  1 = analog pad, 0 = digital
- sticks  in  32  RX, RY, LX, LY = [7:0], [15:8], [23:16], [31:24]
- motor_small  out  8  last command byte 3 of a completed poll
- motor_large  out  8  last command byte 4 of a completed poll
- poll_done  out  1  one-cycle pulse when the final byte of a poll is received

Behaviour:
- Reset or PPB_packet_reset, both synchronous, high priority over the strobe:
  - state = WAIT_ADDR, byte_idx = 0, PPB_reply = 8'hFF, PPB_reply_en = 0, PPB_ack_strobe = 0, poll_done = 0.
  - motor_small/motor_large clear only on reset, never on packet reset.
- Reply timing:
  - Each output is registered and updates the cycle after the PPB_command_strobe of byte k.
  - That update presents the reply for byte k+1; the port samples it at the first falling edge of byte k+1.
  - PPB_ack_strobe is a single cycle, coincident with the reply update, and only when byte k+1 exists.
- States:
  - WAIT_ADDR:
    - On strobe with cmd == PAD_ADDR: latch the buttons/sticks/analog_mode snapshot, set last_idx = 4 (digital) or 8 (analog).
    - Reply = ID (0x41 or 0x73), reply_en = 1, ack, byte_idx = 1, go to WAIT_POLL.
    - Any other cmd (e.g. 0x81 memory card): go to IGNORE, reply_en = 0, no ack.
  - WAIT_POLL:
    - On strobe with cmd == CMD_POLL: reply = 8'h5A, ack, byte_idx = 2, go to DATA.
    - Else go to IGNORE, reply_en = 0, reply = 8'hFF, no ack.
  - DATA:
    - On strobe: byte_idx++. Capture cmd into motor_small_shadow when byte_idx == 3 and motor_large_shadow when byte_idx == 4.
    - If the new byte_idx <= last_idx: reply = snapshot byte[byte_idx], ack.
    - Byte order: 3 = btn lo, 4 = btn hi, 5 = RX, 6 = RY, 7 = LX, 8 = LY.
    - On the strobe of byte last_idx: no ack, reply_en = 0, reply = 8'hFF, poll_done pulse, copy shadows to motor outputs, go to DONE.
  - IGNORE / DONE: ignore strobes, no acks, outputs held until packet reset.
- Snapshot is taken once per packet; input changes mid-packet do not alter the reply.
- byte_idx is 4 bits and never wraps; extra strobes in DONE have no effect.
- PPB_packet_reset mid-packet aborts: no poll_done, motor outputs unchanged.

Decomposition:
- Package psx_pkg holds:
  - state enum {WAIT_ADDR, WAIT_POLL, DATA, IGNORE, DONE}.
  - Constants PSX_ID_DIGITAL = 8'h41, PSX_ID_ANALOG = 8'h73, PSX_REPLY_MAGIC = 8'h5A, PSX_REPLY_IDLE = 8'hFF, PSX_LAST_IDX_DIGITAL = 4, PSX_LAST_IDX_ANALOG = 8.
- One sub-module, psx_pad_reply_select: combinational byte_idx + snapshot -> reply byte mux.

Test Plan:
- Digital poll with buttons = 16'hFFFE, commands 01,42,00,00,00 -> replies 41,5A,FE,FF; 4 acks total; poll_done after byte 5; reply_en = 0 afterwards.
- Analog poll with sticks = 32'h80_7F_10_F0, commands 01,42,00,AA,55,00,00,00,00 -> replies 73,5A,btnlo,btnhi,F0,10,7F,80; 8 acks; motor_small = AA, motor_large = 55 only after poll_done.
- First byte 81 -> reply_en stays 0, no ack on any later strobe until PPB_packet_reset; then 01 is accepted normally.
- Commands 01,43 -> exactly one ack; reply_en = 0 after the second strobe; no poll_done.
- PPB_packet_reset after byte 3 of a poll with motor bytes 11,22 -> motors keep previous values; state returns to WAIT_ADDR; reply = FF.
- Buttons changed after the byte-1 strobe -> bytes 3/4 still return the snapshot values; PPB_packet_reset asserted in the same cycle as a strobe -> reset wins, no ack.
